// File: rtl/rp_seq.sv
// Register-pair sequencer: reads a 16-bit pair from the 8-bit register file,
// applies INC/DEC/ADD/LOAD and writes both bytes back on one edge.
module rp_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [1:0]  req_rp,
  input  logic [15:0] req_operand,
  output logic [2:0]  raddr_hi,
  output logic [2:0]  raddr_lo,
  input  logic [7:0]  rdata_hi,
  input  logic [7:0]  rdata_lo,
  output logic        wen_hi,
  output logic        wen_lo,
  output logic [2:0]  waddr_hi,
  output logic [2:0]  waddr_lo,
  output logic [7:0]  wdata_hi,
  output logic [7:0]  wdata_lo,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [15:0] resp_result,
  output logic        resp_carry,
  output logic        resp_err
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

  localparam logic [1:0] OpInc  = 2'd0;
  localparam logic [1:0] OpDec  = 2'd1;
  localparam logic [1:0] OpAdd  = 2'd2;
  localparam logic [1:0] OpLoad = 2'd3;
  localparam logic [1:0] RpBad  = 2'd3;

  state_e      state_q;
  logic [1:0]  op_q;
  logic [15:0] operand_q;
  logic [2:0]  pair_hi_q, pair_lo_q;
  logic        wen_q;
  logic        resp_valid_q;
  logic [15:0] result_q;
  logic        carry_q;
  logic        err_q;

  logic [15:0] pair_in;
  logic [16:0] sum;

  assign pair_in = {rdata_hi, rdata_lo};

  // Bit 16 doubles as carry: INC overflow, DEC borrow (wraps to 1FFFF), ADD carry-out.
  always_comb begin
    sum = '0;
    unique case (op_q)
      OpInc:   sum = {1'b0, pair_in} + 17'd1;
      OpDec:   sum = {1'b0, pair_in} - 17'd1;
      OpAdd:   sum = {1'b0, pair_in} + {1'b0, operand_q};
      OpLoad:  sum = {1'b0, operand_q};
      default: sum = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      op_q         <= OpInc;
      operand_q    <= '0;
      pair_hi_q    <= '0;
      pair_lo_q    <= '0;
      wen_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      result_q     <= '0;
      carry_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      wen_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            op_q      <= req_op;
            operand_q <= req_operand;
            if (req_rp == RpBad) begin
              state_q      <= StResp;
              resp_valid_q <= 1'b1;
              result_q     <= '0;
              carry_q      <= 1'b0;
              err_q        <= 1'b1;
            end else begin
              pair_hi_q <= {req_rp, 1'b0};
              pair_lo_q <= {req_rp, 1'b1};
              err_q     <= 1'b0;
              if (req_op == OpLoad) begin
                state_q <= StWrite;
                wen_q   <= 1'b1;
              end else begin
                state_q <= StRead;
              end
            end
          end
        end
        StRead: begin
          state_q <= StWrite;
          wen_q   <= 1'b1;
        end
        StWrite: begin
          state_q      <= StResp;
          resp_valid_q <= 1'b1;
          result_q     <= sum[15:0];
          carry_q      <= (op_q == OpLoad) ? 1'b0 : sum[16];
        end
        StResp: begin
          if (resp_ready) begin
            state_q      <= StIdle;
            resp_valid_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready   = (state_q == StIdle);
  assign raddr_hi    = pair_hi_q;
  assign raddr_lo    = pair_lo_q;
  assign waddr_hi    = pair_hi_q;
  assign waddr_lo    = pair_lo_q;
  assign wen_hi      = wen_q;
  assign wen_lo      = wen_q;
  assign wdata_hi    = sum[15:8];
  assign wdata_lo    = sum[7:0];
  assign resp_valid  = resp_valid_q;
  assign resp_result = result_q;
  assign resp_carry  = carry_q;
  assign resp_err    = err_q;

endmodule

// File: tb/tb_rp_seq.sv
// Bench for rp_seq: behavioural register file plus a scoreboard of expected responses.
module tb_rp_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [1:0]  req_op, req_rp;
  logic [15:0] req_operand;
  logic [2:0]  raddr_hi, raddr_lo, waddr_hi, waddr_lo;
  logic [7:0]  rdata_hi, rdata_lo, wdata_hi, wdata_lo;
  logic        wen_hi, wen_lo;
  logic        resp_valid, resp_ready;
  logic [15:0] resp_result;
  logic        resp_carry, resp_err;

  always #5 clk = ~clk;

  rp_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_rp      (req_rp),
    .req_operand (req_operand),
    .raddr_hi    (raddr_hi),
    .raddr_lo    (raddr_lo),
    .rdata_hi    (rdata_hi),
    .rdata_lo    (rdata_lo),
    .wen_hi      (wen_hi),
    .wen_lo      (wen_lo),
    .waddr_hi    (waddr_hi),
    .waddr_lo    (waddr_lo),
    .wdata_hi    (wdata_hi),
    .wdata_lo    (wdata_lo),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_carry  (resp_carry),
    .resp_err    (resp_err)
  );

  // Register file: registered-address read, posedge write.
  logic [7:0] rf [0:7];
  always_ff @(posedge clk) begin
    rdata_hi <= rf[raddr_hi];
    rdata_lo <= rf[raddr_lo];
    if (wen_hi) rf[waddr_hi] <= wdata_hi;
    if (wen_lo) rf[waddr_lo] <= wdata_lo;
  end

  int wen_cnt = 0;
  int split_cnt = 0;
  always @(posedge clk) begin
    if (wen_hi || wen_lo) wen_cnt <= wen_cnt + 1;
    if (wen_hi !== wen_lo) split_cnt <= split_cnt + 1;
  end

  typedef struct packed {
    logic [15:0] result;
    logic        carry;
    logic        err;
  } resp_t;

  resp_t      sb[$];
  logic [7:0] mdl [0:7];
  int         checks = 0;
  int         errors = 0;

  // Reference model of the pair operation; updates the bench's register image.
  function automatic resp_t model(input logic [1:0] op, input logic [1:0] rp,
                                  input logic [15:0] operand);
    resp_t       r;
    int          idx;
    int          p;
    int          s;
    r = '0;
    if (rp == 2'd3) begin
      r.err = 1'b1;
      return r;
    end
    idx = 2 * int'(rp);
    p   = int'({mdl[idx], mdl[idx+1]});
    case (op)
      2'd0: begin s = p + 1; r.carry = (p == 65535); end
      2'd1: begin s = p - 1; r.carry = (p == 0); end
      2'd2: begin s = p + int'(operand); r.carry = (s > 65535); end
      default: s = int'(operand);
    endcase
    r.result   = 16'(s & 32'hFFFF);
    mdl[idx]   = r.result[15:8];
    mdl[idx+1] = r.result[7:0];
    return r;
  endfunction

  // Drives one request, pushes its expected response, and returns what the DUT did.
  task automatic issue(input logic [1:0] op, input logic [1:0] rp, input logic [15:0] operand,
                       output int lat, output logic [2:0] rhi, output logic [2:0] rlo,
                       output resp_t got, output bit tmo);
    int n;
    n   = 0;
    tmo = 1'b0;
    req_valid = 1'b1; req_op = op; req_rp = rp; req_operand = operand;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) tmo = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    sb.push_back(model(op, rp, operand));
    rhi = raddr_hi;
    rlo = raddr_lo;
    lat = 0;
    while (!resp_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!resp_valid) tmo = 1'b1;
    got = {resp_result, resp_carry, resp_err};
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
    checks++;
    if ({resp_valid, wen_hi, wen_lo} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got valid/wen %b expected 000",
                         {resp_valid, wen_hi, wen_lo});
    end
    checks++;
    if ({raddr_hi, raddr_lo, resp_result, resp_carry, resp_err} !== 24'h0) begin
      errors++; $display("FAIL reset_data: got raddr %0d/%0d result %h c%b e%b expected zeros",
                         raddr_hi, raddr_lo, resp_result, resp_carry, resp_err);
    end
  endtask

  task automatic test_inc;
    int lat; logic [2:0] rhi, rlo; resp_t got, exp; bit tmo; int w0;
    issue(2'd3, 2'd2, 16'h12FF, lat, rhi, rlo, got, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || lat != 1 || got !== exp) begin
      errors++; $display("FAIL load_hl: got %h lat %0d tmo %b expected %h lat 1", got, lat, tmo, exp);
    end
    w0 = wen_cnt;
    issue(2'd0, 2'd2, 16'h0000, lat, rhi, rlo, got, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || got !== exp) begin
      errors++; $display("FAIL inc_resp: got %h tmo %b expected %h", got, tmo, exp);
    end
    checks++;
    if (lat != 2) begin
      errors++; $display("FAIL inc_latency: got %0d expected 2", lat);
    end
    checks++;
    if (rhi !== 3'd4 || rlo !== 3'd5) begin
      errors++; $display("FAIL inc_raddr: got %0d/%0d expected 4/5", rhi, rlo);
    end
    checks++;
    if (rf[4] !== 8'h13 || rf[5] !== 8'h00 || wen_cnt - w0 != 1) begin
      errors++; $display("FAIL inc_write: got H=%h L=%h wen %0d expected 13/00 wen 1",
                         rf[4], rf[5], wen_cnt - w0);
    end
  endtask

  task automatic test_dec;
    int lat; logic [2:0] rhi, rlo; resp_t got, exp; bit tmo;
    issue(2'd3, 2'd0, 16'h0000, lat, rhi, rlo, got, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || got !== exp) begin
      errors++; $display("FAIL load_bc: got %h expected %h", got, exp);
    end
    issue(2'd1, 2'd0, 16'h0000, lat, rhi, rlo, got, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || lat != 2 || got !== exp || got !== {16'hFFFF, 1'b1, 1'b0}) begin
      errors++; $display("FAIL dec_wrap: got %h lat %0d expected %h lat 2", got, lat, exp);
    end
    checks++;
    if (rf[0] !== 8'hFF || rf[1] !== 8'hFF) begin
      errors++; $display("FAIL dec_write: got B=%h C=%h expected FF/FF", rf[0], rf[1]);
    end
  endtask

  task automatic test_add_load;
    int lat; logic [2:0] rhi, rlo; resp_t got, exp; bit tmo; int w0;
    issue(2'd3, 2'd1, 16'h8001, lat, rhi, rlo, got, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || got !== exp) begin
      errors++; $display("FAIL load_de: got %h expected %h", got, exp);
    end
    issue(2'd2, 2'd1, 16'h8000, lat, rhi, rlo, got, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || lat != 2 || got !== exp || got !== {16'h0001, 1'b1, 1'b0}) begin
      errors++; $display("FAIL add_carry: got %h lat %0d expected %h lat 2", got, lat, exp);
    end
    w0 = wen_cnt;
    issue(2'd3, 2'd1, 16'hABCD, lat, rhi, rlo, got, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || lat != 1 || got !== exp) begin
      errors++; $display("FAIL load_abcd: got %h lat %0d expected %h lat 1", got, lat, exp);
    end
    checks++;
    if (rf[2] !== 8'hAB || rf[3] !== 8'hCD || wen_cnt - w0 != 1) begin
      errors++; $display("FAIL load_write: got D=%h E=%h wen %0d expected AB/CD wen 1",
                         rf[2], rf[3], wen_cnt - w0);
    end
  endtask

  task automatic test_error;
    int lat; logic [2:0] rhi, rlo; resp_t got, exp; bit tmo; int w0;
    w0 = wen_cnt;
    issue(2'd0, 2'd3, 16'h1234, lat, rhi, rlo, got, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || lat != 0 || got !== exp || got !== {16'h0000, 1'b0, 1'b1}) begin
      errors++; $display("FAIL err_resp: got %h lat %0d expected %h lat 0", got, lat, exp);
    end
    checks++;
    if (wen_cnt != w0) begin
      errors++; $display("FAIL err_nowrite: got %0d wen pulses expected 0", wen_cnt - w0);
    end
  endtask

  task automatic test_back_to_back;
    int n; resp_t exp; int stall_bad;
    stall_bad = 0;
    req_valid = 1'b1; req_op = 2'd0; req_rp = 2'd1; req_operand = 16'h0000;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    sb.push_back(model(2'd0, 2'd1, 16'h0000));
    req_op = 2'd3; req_rp = 2'd2; req_operand = 16'h5555;
    n = 0;
    while (!resp_valid && n < 20) begin @(posedge clk); #1; n++; end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (req_ready !== 1'b0 || resp_valid !== 1'b1 ||
          {resp_result, resp_carry, resp_err} !== sb[0]) begin
        errors++; stall_bad++;
        $display("FAIL stall_hold: cycle %0d ready %b valid %b resp %h expected 0 1 %h",
                 i, req_ready, resp_valid, {resp_result, resp_carry, resp_err}, sb[0]);
      end
      @(posedge clk); #1;
    end
    exp = sb.pop_front();
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL stall_idle: got ready %b expected 1", req_ready);
    end
    @(posedge clk); #1;
    sb.push_back(model(2'd3, 2'd2, 16'h5555));
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL next_accept: got ready %b valid %b expected 0 0",
                         req_ready, resp_valid);
    end
    @(posedge clk); #1;
    exp = sb.pop_front();
    checks++;
    if (resp_valid !== 1'b1 || {resp_result, resp_carry, resp_err} !== exp) begin
      errors++; $display("FAIL next_resp: got valid %b resp %h expected 1 %h",
                         resp_valid, {resp_result, resp_carry, resp_err}, exp);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    checks++;
    if (rf[2] !== 8'hAB || rf[3] !== 8'hCE || rf[4] !== 8'h55 || rf[5] !== 8'h55) begin
      errors++; $display("FAIL b2b_write: got DE=%h%h HL=%h%h expected ABCE/5555",
                         rf[2], rf[3], rf[4], rf[5]);
    end
  endtask

  task automatic test_reset_in_read;
    int lat; logic [2:0] rhi, rlo; resp_t got, exp; bit tmo; int w0; int n;
    issue(2'd3, 2'd0, 16'h1234, lat, rhi, rlo, got, tmo);
    exp = sb.pop_front();
    checks++;
    if (tmo || got !== exp) begin
      errors++; $display("FAIL load_bc2: got %h expected %h", got, exp);
    end
    w0 = wen_cnt;
    req_valid = 1'b1; req_op = 2'd0; req_rp = 2'd0; req_operand = 16'h0000;
    n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0 ||
        {raddr_hi, raddr_lo, resp_result, resp_carry, resp_err} !== 24'h0) begin
      errors++; $display("FAIL rst_read_outs: got ready %b valid %b raddr %0d/%0d resp %h",
                         req_ready, resp_valid, raddr_hi, raddr_lo,
                         {resp_result, resp_carry, resp_err});
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (wen_cnt != w0 || rf[0] !== 8'h12 || rf[1] !== 8'h34 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL rst_read_pair: got wen %0d BC=%h%h valid %b expected 0 1234 0",
                         wen_cnt - w0, rf[0], rf[1], resp_valid);
    end
    checks++;
    if (split_cnt != 0) begin
      errors++; $display("FAIL split_write: got %0d split cycles expected 0", split_cnt);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_rp = '0; req_operand = '0;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    test_reset;
    test_inc;
    test_dec;
    test_add_load;
    test_error;
    test_back_to_back;
    test_reset_in_read;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
